regfile_seq: RTL and testbench

Command sequencer that drives the initiator side of the 8x8 register file: it accepts one register-transfer command at a time over a valid/ready handshake, issues the register-file reads, computes an 8-bit result, and writes it back. It sits between the datapath controller or testbench host and the register file. It honours the register file's rule that reads are serviced only on cycles with write-enable low.

---
 rtl/regfile_seq.sv | 210 +++++++++++++++++++++
 tb/tb_regfile_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_seq.sv
// regfile_seq: command sequencer on the initiator side of an 8x8 register file.
// It takes one register-transfer command at a time, reads the sources, computes
// an 8-bit result, writes it back and reports completion on a one-cycle pulse.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is decoded from state and is high only in IDLE. There is no input
// buffering and no response backpressure; rsp_valid is a single-cycle pulse.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid / cmd_ready            command handshake
//   cmd_op[2:0]                      000 ADD 001 SUB 010 AND 011 OR
//                                    100 XOR 101 MOV 110 LDI 111 RD
//   cmd_rd, cmd_rs1, cmd_rs2         destination / source register addresses
//   cmd_imm                          immediate for LDI
//   rf_read_port_1/2                 register-file read addresses (registered)
//   rf_read_data_1/2                 read data, valid one cycle after the ports
//   rf_write_port_1, rf_write_data   write address / data (registered)
//   rf_write_enable                  write strobe (registered)
//   rsp_valid, rsp_data              completion pulse and result
//   rsp_zero, rsp_carry              result == 0, carry/borrow
//   state_dbg[2:0]                   current FSM state: 0 IDLE, 1 READ, 2 CAPT,
//                                    3 WRITE, 4 RESP, 5 INIT
//
// Optional feature: define REGFILE_SEQ_SCRUB_EN to zero all eight registers
// (addresses 0..7, one per cycle) after every reset before accepting commands.

module regfile_seq #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] rf_read_port_1,
  output logic [ADDR_W-1:0] rf_read_port_2,
  output logic [ADDR_W-1:0] rf_write_port_1,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_enable,
  input  logic [DATA_W-1:0] rf_read_data_1,
  input  logic [DATA_W-1:0] rf_read_data_2,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CAPT  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4,
    S_INIT  = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_RD  = 3'b111;

`ifdef REGFILE_SEQ_SCRUB_EN
  localparam state_t RESET_STATE = S_INIT;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t            state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic              carry_q;   // flag for the result held in rf_write_data

`ifdef REGFILE_SEQ_SCRUB_EN
  // Bit ADDR_W set means all registers have been scrubbed.
  logic [ADDR_W:0]   scrub_cnt;
`endif

  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;

  assign cmd_ready = (state == S_IDLE);
  assign state_dbg = state;

  // Extending both operands by a zero bit makes bit DATA_W the carry for the
  // sum and the borrow (rs1 < rs2) for the difference.
  assign sum_ext  = {1'b0, rf_read_data_1} + {1'b0, rf_read_data_2};
  assign diff_ext = {1'b0, rf_read_data_1} - {1'b0, rf_read_data_2};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res   = sum_ext[DATA_W-1:0];
        alu_carry = sum_ext[DATA_W];
      end
      OP_SUB: begin
        alu_res   = diff_ext[DATA_W-1:0];
        alu_carry = diff_ext[DATA_W];
      end
      OP_AND:  alu_res = rf_read_data_1 & rf_read_data_2;
      OP_OR:   alu_res = rf_read_data_1 | rf_read_data_2;
      OP_XOR:  alu_res = rf_read_data_1 ^ rf_read_data_2;
      OP_MOV:  alu_res = rf_read_data_1;
      default: alu_res = rf_read_data_1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RESET_STATE;
      op_q            <= '0;
      rd_q            <= '0;
      carry_q         <= 1'b0;
      rf_read_port_1  <= '0;
      rf_read_port_2  <= '0;
      rf_write_port_1 <= '0;
      rf_write_data   <= '0;
      rf_write_enable <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_data        <= '0;
      rsp_zero        <= 1'b0;
      rsp_carry       <= 1'b0;
`ifdef REGFILE_SEQ_SCRUB_EN
      scrub_cnt       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q <= cmd_op;
            rd_q <= cmd_rd;
            if (cmd_op == OP_LDI) begin
              // LDI needs no read: write the immediate straight away.
              rf_write_port_1 <= cmd_rd;
              rf_write_data   <= cmd_imm;
              rf_write_enable <= 1'b1;
              carry_q         <= 1'b0;
              state           <= S_WRITE;
            end else begin
              // Ports are presented in READ with write-enable low; they then
              // hold until the next read command.
              rf_read_port_1 <= cmd_rs1;
              rf_read_port_2 <= cmd_rs2;
              state          <= S_READ;
            end
          end
        end
        S_READ: state <= S_CAPT;
        S_CAPT: begin
          if (op_q == OP_RD) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rf_read_data_1;
            rsp_zero  <= (rf_read_data_1 == '0);
            rsp_carry <= 1'b0;
            state     <= S_RESP;
          end else begin
            rf_write_port_1 <= rd_q;
            rf_write_data   <= alu_res;
            rf_write_enable <= 1'b1;
            carry_q         <= alu_carry;
            state           <= S_WRITE;
          end
        end
        S_WRITE: begin
          rf_write_enable <= 1'b0;
          rsp_valid       <= 1'b1;
          rsp_data        <= rf_write_data;
          rsp_zero        <= (rf_write_data == '0);
          rsp_carry       <= carry_q;
          state           <= S_RESP;
        end
        S_RESP: begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
        S_INIT: begin
`ifdef REGFILE_SEQ_SCRUB_EN
          if (!scrub_cnt[ADDR_W]) begin
            rf_write_port_1 <= scrub_cnt[ADDR_W-1:0];
            rf_write_data   <= '0;
            rf_write_enable <= 1'b1;
            scrub_cnt       <= scrub_cnt + 1'b1;
          end else begin
            rf_write_enable <= 1'b0;
            state           <= S_IDLE;
          end
`else
          state <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_seq.sv
module tb_regfile_seq;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int RW = 32 + 2 + DW;   // {cycle, carry, zero, data}
  localparam int EW = 32 + AW + DW;  // {cycle, addr, data}

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, ANDO = 3'b010, ORO = 3'b011;
  localparam logic [2:0] XORO = 3'b100, MOV = 3'b101, LDI = 3'b110, RD = 3'b111;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [DW-1:0] cmd_imm;
  logic [AW-1:0] rf_read_port_1, rf_read_port_2, rf_write_port_1;
  logic [DW-1:0] rf_write_data;
  logic          rf_write_enable;
  logic [DW-1:0] rf_read_data_1, rf_read_data_2;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_zero, rsp_carry;
  logic [2:0]    state_dbg;

  regfile_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .rf_read_port_1(rf_read_port_1), .rf_read_port_2(rf_read_port_2),
    .rf_write_port_1(rf_write_port_1), .rf_write_data(rf_write_data),
    .rf_write_enable(rf_write_enable),
    .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_carry(rsp_carry), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- register file model (responder) ----------------
  logic [DW-1:0] rf_mem [8];
  always @(posedge clk) begin
    if (rf_write_enable) rf_mem[rf_write_port_1] <= rf_write_data;
    else begin
      rf_read_data_1 <= rf_mem[rf_read_port_1];
      rf_read_data_2 <= rf_mem[rf_read_port_2];
    end
  end

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];   // expected responses
  logic [EW-1:0] wr_q[$];    // expected write pulses
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [RW-1:0] e_rsp;
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
      else begin
        e_rsp = exp_q.pop_front();
        check("rsp_cycle", 64'(cyc), 64'(e_rsp[RW-1 -: 32]));
        check("rsp_data",  64'(rsp_data),  64'(e_rsp[DW-1:0]));
        check("rsp_zero",  64'(rsp_zero),  64'(e_rsp[DW]));
        check("rsp_carry", 64'(rsp_carry), 64'(e_rsp[DW+1]));
      end
    end
  end

  logic [EW-1:0] e_wr;
  always @(negedge clk) begin
    if (rst_n && rf_write_enable) begin
      if (wr_q.size() == 0) check("write_unexpected", 64'd1, 64'd0);
      else begin
        e_wr = wr_q.pop_front();
        check("write_cycle", 64'(cyc), 64'(e_wr[EW-1 -: 32]));
        check("write_addr",  64'(rf_write_port_1), 64'(e_wr[DW+AW-1:DW]));
        check("write_data",  64'(rf_write_data),   64'(e_wr[DW-1:0]));
      end
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [8];
  logic [DW-1:0] last_rsp_data;
  int  prev_free;   // negedge cycle at which cmd_ready should next rise
  bit  have_prev;

  // Returns {carry, zero, result}.
  function automatic logic [DW+1:0] model(input logic [2:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic [DW-1:0] imm);
    int unsigned r;
    bit c;
    c = 1'b0;
    case (op)
      ADD:  begin r = int'(a) + int'(b); c = (r > 255); r = r % 256; end
      SUB:  begin c = (a < b); r = (256 + int'(a) - int'(b)) % 256; end
      ANDO: r = int'(a & b);
      ORO:  r = int'(a | b);
      XORO: r = int'(a ^ b);
      LDI:  r = int'(imm);
      default: r = int'(a);  // MOV, RD
    endcase
    return {c, (r == 0), r[DW-1:0]};
  endfunction

  // ---------------- driver ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_data",  64'(rsp_data), 64'd0);
    check("reset_flags",     64'({rsp_zero, rsp_carry}), 64'd0);
    check("reset_we",        64'(rf_write_enable), 64'd0);
    check("reset_wport",     64'({rf_write_port_1, rf_write_data}), 64'd0);
    check("reset_rports",    64'({rf_read_port_1, rf_read_port_2}), 64'd0);
`ifdef REGFILE_SEQ_SCRUB_EN
    check("reset_ready", 64'(cmd_ready), 64'd0);
    check("reset_state", 64'(state_dbg), 64'd5);
`else
    check("reset_ready", 64'(cmd_ready), 64'd1);
    check("reset_state", 64'(state_dbg), 64'd0);
`endif
    rst_n = 1'b1;
`ifdef REGFILE_SEQ_SCRUB_EN
    for (int i = 0; i < 8; i++) begin
      wr_q.push_back({32'(cyc + 1 + i), AW'(i), {DW{1'b0}}});
      ref_mem[i] = '0;
    end
    prev_free = cyc + 9;
`else
    prev_free = cyc;
`endif
    have_prev = 1'b1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic [DW-1:0] imm, input bit kill = 1'b0);
    int guard;
    bit waited;
    int acc;
    int lat;
    logic [DW+1:0] m;
    cmd_valid = 1'b1;
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    guard = 0;
    waited = 1'b0;
    while (!cmd_ready) begin
      waited = 1'b1;
      @(negedge clk);
      guard++;
      if (guard > 50) begin
        check("ready_timeout", 64'd0, 64'd1);
        cmd_valid = 1'b0;
        return;
      end
    end
    if (have_prev) begin
      if (waited) check("ready_cycle", 64'(cyc), 64'(prev_free));
      else        check("ready_early", 64'(cyc >= prev_free), 64'd1);
    end
    acc = cyc + 1;  // edge on which the command transfers
    m = model(op, ref_mem[rs1], ref_mem[rs2], imm);
    lat = (op == LDI) ? 1 : (op == RD) ? 2 : 3;
    if (op != RD) wr_q.push_back({32'(acc + ((op == LDI) ? 0 : 2)), rd, m[DW-1:0]});
    @(negedge clk);
    cmd_valid = 1'b0;
    if (kill) begin
      // Reset lands mid-cycle while rf_write_enable is high.
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("kill_we_drop", 64'(rf_write_enable), 64'd0);
      check("kill_rsp_valid", 64'(rsp_valid), 64'd0);
      have_prev = 1'b0;
      do_reset();
    end else begin
      exp_q.push_back({32'(acc + lat), m[DW+1], m[DW], m[DW-1:0]});
      if (op != RD) ref_mem[rd] = m[DW-1:0];
      last_rsp_data = m[DW-1:0];
      prev_free = acc + lat + 1;
      have_prev = 1'b1;
    end
  endtask

  task automatic random_cmds(input int n);
    for (int i = 0; i < n; i++) begin
      issue(3'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            AW'($urandom_range(0, 7)), DW'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
    have_prev = 1'b0;
    prev_free = 0;
    last_rsp_data = '0;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    do_reset();
`ifndef REGFILE_SEQ_SCRUB_EN
    for (int i = 0; i < 8; i++) issue(LDI, AW'(i), 3'd0, 3'd0, DW'($urandom_range(0, 255)));
`endif
    // Directed sequence, issued back to back so each command is held while busy.
    issue(LDI, 3'd1, 3'd0, 3'd0, 8'hF0);
    issue(LDI, 3'd2, 3'd0, 3'd0, 8'h20);
    issue(ADD, 3'd3, 3'd1, 3'd2, 8'h00);
    issue(SUB, 3'd4, 3'd2, 3'd1, 8'h00);
    issue(XORO, 3'd5, 3'd1, 3'd1, 8'h00);
    issue(RD,  3'd0, 3'd3, 3'd0, 8'h00);
    issue(ADD, 3'd1, 3'd1, 3'd1, 8'h00);
    issue(RD,  3'd0, 3'd1, 3'd0, 8'h00);
    issue(SUB, 3'd6, 3'd1, 3'd1, 8'h00);
    issue(MOV, 3'd7, 3'd4, 3'd0, 8'h00);
    random_cmds(60);
    // Reset during WRITE: the write is lost and no response is issued.
    issue(ADD, 3'd2, 3'd3, 3'd4, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) issue(RD, 3'd0, AW'(i), 3'd0, 8'h00);
    random_cmds(20);
    repeat (10) @(negedge clk);
    check("rsp_queue_empty",   64'(exp_q.size()), 64'd0);
    check("write_queue_empty", 64'(wr_q.size()), 64'd0);
    check("rsp_data_hold",     64'(rsp_data), 64'(last_rsp_data));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
